mgc_out_wait_arb: RTL and testbench

- Round-robin arbiter that shares one downstream ld/vd/d write channel among n_req producers.
- The downstream channel is typically the input side of an mgc_out_fifo_wait or mgc_out_buf_wait.
- A grant is locked to one producer for a burst of up to max_burst transfers. The grant releases early if that producer drops ld.
- Arbitration state is registered: one idle cycle occurs between grants.

---
 rtl/mgc_out_wait_arb_if.sv | 39 +++
 rtl/mgc_out_wait_arb.sv | 157 +++++++++++++++
 tb/tb_mgc_out_wait_arb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mgc_out_wait_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mgc_out_wait_arb_if
// Description : Bundle of the producer-side and downstream-side handshake
//               signals of the round-robin write-channel arbiter.
//                 req_ld  [n_req]        producer load requests
//                 req_d   [n_req*width]  producer data, i at [i*width +: width]
//                 req_vd  [n_req]        per-producer accept
//                 ld, d                  downstream load / data
//                 vd                     downstream ready
//                 gnt_vld, gnt_id        grant status
//               master : arbiter side, slave : producer/downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mgc_out_wait_arb_if #(
  parameter int unsigned width = 8,
  parameter int unsigned n_req = 4,
  parameter int unsigned id_w  = 2
);
  logic [n_req-1:0]       req_ld;
  logic [n_req*width-1:0] req_d;
  logic [n_req-1:0]       req_vd;
  logic                   ld;
  logic [width-1:0]       d;
  logic                   vd;
  logic                   gnt_vld;
  logic [id_w-1:0]        gnt_id;

  modport master (
    input  req_ld, req_d, vd,
    output req_vd, ld, d, gnt_vld, gnt_id
  );

  modport slave (
    output req_ld, req_d, vd,
    input  req_vd, ld, d, gnt_vld, gnt_id
  );
endinterface
`default_nettype wire

// File: rtl/mgc_out_wait_arb.sv
`default_nettype none
// ============================================================================
// Module      : mgc_out_wait_arb
// Description : Round-robin arbiter sharing one downstream ld/vd/d write
//               channel among n_req producers. A grant is held for up to
//               max_burst transfers, released early when the producer drops
//               ld, and followed by one idle arbitration cycle.
// Ports       : clk   rising-edge clock
//               arst  asynchronous reset, active low
//               en    clock enable (active level ph_en)
//               srst  synchronous reset (active level ph_srst)
//               bus   handshake bundle (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module mgc_out_wait_arb #(
  parameter int unsigned rscid     = 0,
  parameter int unsigned width     = 8,
  parameter int unsigned n_req     = 4,
  parameter int unsigned id_w      = 2,
  parameter int unsigned max_burst = 4,
  parameter logic        ph_en     = 1'b1,
  parameter logic        ph_srst   = 1'b1
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               en,
  input  logic               srst,
  mgc_out_wait_arb_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0]      c_cnt_last = 8'(max_burst - 1);
  localparam logic [id_w:0]   c_nreq     = (id_w + 1)'(n_req);
  localparam logic [id_w-1:0] c_id_last  = id_w'(n_req - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [id_w-1:0] r_ptr;
  logic [id_w-1:0] w_ptr_nxt;
  logic [id_w-1:0] r_gnt;
  logic [id_w-1:0] w_gnt_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;

  logic [n_req-1:0] w_gsel;
  logic [width-1:0] w_gdata;
  logic             w_gld;
  logic             w_xfer;
  logic             w_any;
  logic [id_w:0]    w_idx;
  logic [id_w-1:0]  w_win;
  logic             w_unused;

  // Resource ID is informational only.
  assign w_unused = ^(32'(rscid));

  // One-hot decode of the granted producer plus its data.
  always_comb begin
    w_gsel  = '0;
    w_gdata = '0;
    for (int i = 0; i < n_req; i++) begin
      if (r_gnt == id_w'(i)) begin
        w_gsel[i] = 1'b1;
        w_gdata   = bus.req_d[i*width +: width];
      end
    end
  end

  assign w_gld  = |(bus.req_ld & w_gsel);
  assign w_xfer = w_gld & bus.vd;
  assign w_any  = |bus.req_ld;

  // Round-robin search starting at r_ptr. Scanning offsets from highest to
  // lowest lets the smallest offset (closest to the pointer) win.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (id_w + 1)'(k);
      if (w_idx >= c_nreq) begin
        w_idx = w_idx - c_nreq;
      end
      if (bus.req_ld[w_idx[id_w-1:0]]) begin
        w_win = w_idx[id_w-1:0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    bus.ld      = 1'b0;
    bus.d       = '0;
    bus.req_vd  = '0;
    bus.gnt_vld = 1'b0;
    bus.gnt_id  = r_gnt;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end

      BUSY: begin
        bus.ld      = w_gld;
        bus.d       = w_gdata;
        bus.req_vd  = w_gsel & {n_req{bus.vd}};
        bus.gnt_vld = 1'b1;

        // Dropping ld releases even when vd is also low.
        if (!w_gld || (w_xfer && (r_cnt == c_cnt_last))) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (r_gnt == c_id_last) ? '0 : r_gnt + 1'b1;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State registers: async reset, then sync reset, then clock enable.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else if (srst == ph_srst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else if (en == ph_en) begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mgc_out_wait_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mgc_out_wait_arb
// Description : Directed self-checking bench for mgc_out_wait_arb. Instance A
//               uses n_req=4/max_burst=4, instance B n_req=3/max_burst=1.
//               Observed vector = {gnt_vld, gnt_id, ld, req_vd, d}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mgc_out_wait_arb;

  logic clk;
  logic a_arst, a_en, a_srst;
  logic b_arst, b_en, b_srst;
  int   total;
  int   bad;

  mgc_out_wait_arb_if #(.width(8), .n_req(4), .id_w(2)) a_if ();
  mgc_out_wait_arb_if #(.width(8), .n_req(3), .id_w(2)) b_if ();

  mgc_out_wait_arb #(
    .rscid(1), .width(8), .n_req(4), .id_w(2), .max_burst(4),
    .ph_en(1'b1), .ph_srst(1'b1)
  ) u_dut_a (
    .clk (clk),
    .arst(a_arst),
    .en  (a_en),
    .srst(a_srst),
    .bus (a_if)
  );

  mgc_out_wait_arb #(
    .rscid(2), .width(8), .n_req(3), .id_w(2), .max_burst(1),
    .ph_en(1'b1), .ph_srst(1'b1)
  ) u_dut_b (
    .clk (clk),
    .arst(b_arst),
    .en  (b_en),
    .srst(b_srst),
    .bus (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected vectors for instance A (producer i data = 8'hA0 + i).
  function automatic logic [15:0] busy_a(int g, logic l, logic v);
    logic [3:0] sel;
    sel = 4'b0001 << g;
    return {1'b1, 2'(g), l, (v ? sel : 4'b0000), 8'(8'hA0 + g)};
  endfunction

  function automatic logic [15:0] idle_a(int g);
    return {1'b0, 2'(g), 1'b0, 4'b0000, 8'h00};
  endfunction

  // Expected vectors for instance B (producer i data = 8'hC0 + i).
  function automatic logic [14:0] busy_b(int g);
    logic [2:0] sel;
    sel = 3'b001 << g;
    return {1'b1, 2'(g), 1'b1, sel, 8'(8'hC0 + g)};
  endfunction

  function automatic logic [14:0] idle_b(int g);
    return {1'b0, 2'(g), 1'b0, 3'b000, 8'h00};
  endfunction

  task automatic chk_a(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {a_if.gnt_vld, a_if.gnt_id, a_if.ld, a_if.req_vd, a_if.d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {b_if.gnt_vld, b_if.gnt_id, b_if.ld, b_if.req_vd, b_if.d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    a_arst      = 1'b1;
    a_en        = 1'b1;
    a_srst      = 1'b0;
    b_arst      = 1'b1;
    b_en        = 1'b1;
    b_srst      = 1'b0;
    a_if.req_ld = 4'b1111;
    a_if.req_d  = 32'hA3A2A1A0;
    a_if.vd     = 1'b1;
    b_if.req_ld = 3'b111;
    b_if.req_d  = 24'hC2C1C0;
    b_if.vd     = 1'b1;
    #1;
    a_arst = 1'b0;
    b_arst = 1'b0;

    // Reset with all producers requesting: outputs stay idle.
    tick();
    chk_a("rst_a", idle_a(0));
    a_arst = 1'b1;

    // Round robin, all active: 0,1,2,3,0 with 4 transfers then one bubble.
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        chk_a($sformatf("rr_g%0d_b%0d", n, b), busy_a(n % 4, 1'b1, 1'b1));
      end
      tick();
      chk_a($sformatf("rr_idle%0d", n), idle_a(n % 4));
    end

    // Early release: producer 2 alone, two transfers then drops ld.
    a_if.req_ld = 4'b0100;
    tick();
    chk_a("er_b0", busy_a(2, 1'b1, 1'b1));
    tick();
    chk_a("er_b1", busy_a(2, 1'b1, 1'b1));
    a_if.req_ld = 4'b0000;
    #1;
    chk_a("er_drop", busy_a(2, 1'b0, 1'b1));
    tick();
    chk_a("er_idle", idle_a(2));

    // Pointer is 3: a request from 0 only is reached by wrap-around.
    a_if.req_ld = 4'b0001;
    tick();
    chk_a("wrap_g0", busy_a(0, 1'b1, 1'b1));
    a_if.req_ld = 4'b0000;
    #1;
    chk_a("wrap_drop", busy_a(0, 1'b0, 1'b1));
    tick();
    chk_a("wrap_idle", idle_a(0));

    // Backpressure during a burst to producer 1 (pointer now 1).
    a_if.req_ld = 4'b1111;
    tick();
    chk_a("bp_b0", busy_a(1, 1'b1, 1'b1));
    tick();
    chk_a("bp_b1", busy_a(1, 1'b1, 1'b1));
    a_if.vd = 1'b0;
    #1;
    chk_a("bp_stall0", busy_a(1, 1'b1, 1'b0));
    for (int s = 1; s < 5; s++) begin
      tick();
      chk_a($sformatf("bp_stall%0d", s), busy_a(1, 1'b1, 1'b0));
    end
    a_if.vd = 1'b1;
    #1;
    chk_a("bp_resume_b1", busy_a(1, 1'b1, 1'b1));
    tick();
    chk_a("bp_b2", busy_a(1, 1'b1, 1'b1));
    tick();
    chk_a("bp_b3", busy_a(1, 1'b1, 1'b1));
    tick();
    chk_a("bp_idle", idle_a(1));

    // Clock enable low mid-burst to producer 2: counts hold, outputs follow vd.
    tick();
    chk_a("en_b0", busy_a(2, 1'b1, 1'b1));
    tick();
    chk_a("en_b1", busy_a(2, 1'b1, 1'b1));
    a_en = 1'b0;
    #1;
    chk_a("en_off0", busy_a(2, 1'b1, 1'b1));
    tick();
    a_if.vd = 1'b0;
    #1;
    chk_a("en_off1", busy_a(2, 1'b1, 1'b0));
    tick();
    a_if.vd = 1'b1;
    #1;
    chk_a("en_off2", busy_a(2, 1'b1, 1'b1));
    tick();
    a_en = 1'b1;
    #1;
    chk_a("en_on_b1", busy_a(2, 1'b1, 1'b1));
    tick();
    chk_a("en_b2", busy_a(2, 1'b1, 1'b1));
    tick();
    chk_a("en_b3", busy_a(2, 1'b1, 1'b1));
    tick();
    chk_a("en_idle", idle_a(2));

    // Sync reset pulse mid-burst to producer 3.
    tick();
    chk_a("sr_g3", busy_a(3, 1'b1, 1'b1));
    a_srst = 1'b1;
    #1;
    chk_a("sr_pending", busy_a(3, 1'b1, 1'b1));
    tick();
    chk_a("sr_idle", idle_a(0));
    a_srst = 1'b0;
    tick();
    chk_a("sr_ptr0", busy_a(0, 1'b1, 1'b1));

    // Asynchronous reset mid-burst drops outputs without a clock edge.
    a_arst = 1'b0;
    #1;
    chk_a("arst_mid", idle_a(0));

    // Instance B: n_req=3, max_burst=1, single transfer per grant, wrap 2->0.
    chk_b("rst_b", idle_b(0));
    b_arst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_b($sformatf("mb1_g%0d", n), busy_b(n % 3));
      tick();
      chk_b($sformatf("mb1_idle%0d", n), idle_b(n % 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
